// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO register offsets,
// default I/O window base and a small decode helper.
package dmem_pkg;

    // Register offsets inside the 256-byte I/O window
    localparam logic [7:0] OFF_CYCLE  = 8'h00;
    localparam logic [7:0] OFF_GPIO   = 8'h04;
    localparam logic [7:0] OFF_TIMER  = 8'h08;
    localparam logic [7:0] OFF_STATUS = 8'h0C;

    // Default base of the I/O window (low byte must be zero)
    localparam logic [31:0] DEFAULT_MMIO_BASE = 32'hFFFF_FF00;

    // True when a byte address falls inside the I/O window at base
    function automatic logic is_mmio(input logic [31:0] addr, input logic [31:0] base);
        return addr[31:8] == base[31:8];
    endfunction

endpackage

// File: rtl/mmio_timer.sv
// One-shot down-count timer with a sticky expiry flag.
// A load reloads the count and suppresses that cycle's decrement; the flag
// sets on the 1 -> 0 transition and a simultaneous clear loses to the set.
module mmio_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_value,
    input  logic        clr,
    output logic [31:0] count,
    output logic        expired
);

    logic [31:0] r_count;
    logic        r_expired;
    logic        w_expire_evt;

    // Expiry happens only when the last tick is not overridden by a reload
    assign w_expire_evt = !load && (r_count == 32'd1);

    // Count register: reload has priority, otherwise decrement while non-zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= 32'd0;
        end else if (load) begin
            r_count <= load_value;
        end else if (r_count != 32'd0) begin
            r_count <= r_count - 32'd1;
        end
    end

    // Sticky flag: set on expiry, cleared by software, set wins a race
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_expired <= 1'b0;
        end else if (w_expire_evt) begin
            r_expired <= 1'b1;
        end else if (clr) begin
            r_expired <= 1'b0;
        end
    end

    assign count   = r_count;
    assign expired = r_expired;

endmodule

// File: rtl/dmem_responder.sv
// Data-bus responder for the single-cycle MIPS core: word RAM plus an I/O
// window with a free-running cycle counter, GPIO register and a timer.
// Loads are combinational so the core can finish them in one cycle.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          MEM_WORDS = 64,
    parameter logic [31:0] MMIO_BASE = DEFAULT_MMIO_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] gpio_out,
    output logic        timer_irq
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]   r_mem [MEM_WORDS];
    logic [31:0]   r_cycle;
    logic [31:0]   r_gpio;

    logic          w_mmio;
    logic [7:0]    w_off;
    logic [AW-1:0] w_ram_idx;
    logic          w_ram_we;
    logic          w_cycle_we;
    logic          w_gpio_we;
    logic          w_timer_load;
    logic          w_status_clr;
    logic [31:0]   w_timer_count;
    logic          w_expired;

    // Address decode; RAM ignores the upper address bits and therefore aliases
    assign w_mmio       = is_mmio(addr, MMIO_BASE);
    assign w_off        = addr[7:0];
    assign w_ram_idx    = addr[AW+1:2];
    assign w_ram_we     = memwrite && !w_mmio;
    assign w_cycle_we   = memwrite && w_mmio && (w_off == OFF_CYCLE);
    assign w_gpio_we    = memwrite && w_mmio && (w_off == OFF_GPIO);
    assign w_timer_load = memwrite && w_mmio && (w_off == OFF_TIMER);
    assign w_status_clr = memwrite && w_mmio && (w_off == OFF_STATUS) && writedata[0];

    // RAM write; contents are never cleared, reset only blocks the write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
        end else if (w_ram_we) begin
            r_mem[w_ram_idx] <= writedata;
        end
    end

    // Free-running cycle counter; a software write overrides the increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle <= 32'd0;
        end else if (w_cycle_we) begin
            r_cycle <= writedata;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    // GPIO output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gpio <= 32'd0;
        end else if (w_gpio_we) begin
            r_gpio <= writedata;
        end
    end

    mmio_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (w_timer_load),
        .load_value (writedata),
        .clr        (w_status_clr),
        .count      (w_timer_count),
        .expired    (w_expired)
    );

    // Zero-latency read mux; shows pre-edge state during a same-cycle write
    always_comb begin
        readdata = 32'd0;
        if (w_mmio) begin
            case (w_off)
                OFF_CYCLE:  readdata = r_cycle;
                OFF_GPIO:   readdata = r_gpio;
                OFF_TIMER:  readdata = w_timer_count;
                OFF_STATUS: readdata = {31'd0, w_expired};
                default:    readdata = 32'd0;
            endcase
        end else begin
            readdata = r_mem[w_ram_idx];
        end
    end

    assign gpio_out  = r_gpio;
    assign timer_irq = w_expired;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: hand-computed expectations for RAM,
// combinational read timing, CYCLE, TIMER/STATUS, GPIO, unmapped offsets
// and asynchronous reset.
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] gpio_out;
    logic        timer_irq;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_responder #(
        .MEM_WORDS (64),
        .MMIO_BASE (32'hFFFF_FF00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata),
        .gpio_out  (gpio_out),
        .timer_irq (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: count, report mismatch, print one line
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Write one word across a rising edge; leaves addr pointing at it
    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        addr      = a;
        writedata = d;
        memwrite  = 1'b1;
        @(posedge clk);
        #1;
        memwrite  = 1'b0;
    endtask

    // Put an address on the bus and let the combinational read settle
    task automatic peek(input logic [31:0] a);
        addr = a;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        memwrite  = 1'b0;
        addr      = 32'h0;
        writedata = 32'h0;

        // Reset state
        #12;
        peek(32'hFFFF_FF04);
        check("rst_gpio_read", readdata, 32'h0);
        check("rst_gpio_out", gpio_out, 32'h0);
        check("rst_irq", {31'd0, timer_irq}, 32'h0);

        // CYCLE after release: 0, 1, 2
        @(negedge clk);
        reset = 1'b1;
        peek(32'hFFFF_FF00);
        check("cycle_0", readdata, 32'd0);
        tick();
        check("cycle_1", readdata, 32'd1);
        tick();
        check("cycle_2", readdata, 32'd2);

        // RAM write/read and aliasing
        do_write(32'h0000_0010, 32'hDEAD_BEEF);
        peek(32'h0000_0010);
        check("ram_rd", readdata, 32'hDEAD_BEEF);
        peek(32'h0000_0110);
        check("ram_alias", readdata, 32'hDEAD_BEEF);

        // Combinational read shows old data during the write cycle
        do_write(32'h0000_0014, 32'h5);
        addr      = 32'h0000_0014;
        writedata = 32'h1234;
        memwrite  = 1'b1;
        #1;
        check("ram_same_cycle", readdata, 32'h5);
        @(posedge clk);
        #1;
        memwrite = 1'b0;
        check("ram_next_cycle", readdata, 32'h1234);

        // CYCLE write and wrap
        do_write(32'hFFFF_FF00, 32'hFFFF_FFFE);
        check("cycle_load", readdata, 32'hFFFF_FFFE);
        tick();
        check("cycle_max", readdata, 32'hFFFF_FFFF);
        tick();
        check("cycle_wrap", readdata, 32'h0);

        // TIMER countdown 3,2,1,0 with irq on the final edge
        do_write(32'hFFFF_FF08, 32'd3);
        check("tmr_3", readdata, 32'd3);
        check("tmr_irq_3", {31'd0, timer_irq}, 32'h0);
        tick();
        check("tmr_2", readdata, 32'd2);
        tick();
        check("tmr_1", readdata, 32'd1);
        check("tmr_irq_1", {31'd0, timer_irq}, 32'h0);
        tick();
        check("tmr_0", readdata, 32'd0);
        check("tmr_irq_0", {31'd0, timer_irq}, 32'h1);
        tick();
        check("tmr_hold0", readdata, 32'd0);
        check("tmr_irq_sticky", {31'd0, timer_irq}, 32'h1);
        peek(32'hFFFF_FF0C);
        check("status_1", readdata, 32'h1);

        // STATUS write with bit0=0 is ignored, bit0=1 clears
        do_write(32'hFFFF_FF0C, 32'hFFFF_FFFE);
        check("status_nop_irq", {31'd0, timer_irq}, 32'h1);
        do_write(32'hFFFF_FF0C, 32'h1);
        check("status_clr_irq", {31'd0, timer_irq}, 32'h0);
        check("status_clr_rd", readdata, 32'h0);

        // Writing 0 stops without expiry
        do_write(32'hFFFF_FF08, 32'd2);
        do_write(32'hFFFF_FF08, 32'd0);
        tick();
        tick();
        check("tmr_stop_cnt", readdata, 32'd0);
        check("tmr_stop_irq", {31'd0, timer_irq}, 32'h0);

        // Reload during countdown: no decrement on the reload cycle
        do_write(32'hFFFF_FF08, 32'd3);
        tick();
        check("tmr_pre_reload", readdata, 32'd2);
        do_write(32'hFFFF_FF08, 32'd5);
        check("tmr_reload", readdata, 32'd5);
        tick();
        check("tmr_reload_dec", readdata, 32'd4);
        do_write(32'hFFFF_FF08, 32'd0);

        // Set/clear race: set wins
        do_write(32'hFFFF_FF08, 32'd1);
        do_write(32'hFFFF_FF0C, 32'd1);
        check("race_irq", {31'd0, timer_irq}, 32'h1);
        do_write(32'hFFFF_FF0C, 32'd1);
        check("race_clr_irq", {31'd0, timer_irq}, 32'h0);

        // GPIO
        do_write(32'hFFFF_FF04, 32'hA5A5_0F0F);
        check("gpio_out", gpio_out, 32'hA5A5_0F0F);
        check("gpio_rd", readdata, 32'hA5A5_0F0F);

        // Unmapped offset: write ignored, reads 0, RAM at same low bits untouched
        do_write(32'h0000_0020, 32'h77);
        do_write(32'hFFFF_FF20, 32'h1234_5678);
        check("unmapped_rd", readdata, 32'h0);
        check("unmapped_gpio", gpio_out, 32'hA5A5_0F0F);
        peek(32'h0000_0020);
        check("unmapped_ram", readdata, 32'h77);

        // Asynchronous reset mid-cycle
        do_write(32'hFFFF_FF08, 32'd100);
        do_write(32'hFFFF_FF04, 32'd7);
        check("pre_rst_gpio", gpio_out, 32'd7);
        #2;
        reset = 1'b0;
        #1;
        check("arst_gpio", gpio_out, 32'd0);
        peek(32'hFFFF_FF08);
        check("arst_timer", readdata, 32'd0);
        peek(32'hFFFF_FF00);
        check("arst_cycle", readdata, 32'd0);

        // Write during reset is discarded
        do_write(32'hFFFF_FF04, 32'd9);
        check("rst_write_drop", gpio_out, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 110; i++) @(posedge clk);
        #1;
        check("no_irq_after_rst", {31'd0, timer_irq}, 32'h0);
        peek(32'hFFFF_FF08);
        check("timer_idle_after_rst", readdata, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory-side responder for the single-cycle MIPS core's data bus (memwrite, address, writedata, readdata).
- Provides a word-addressed RAM plus a small memory-mapped I/O window containing a cycle counter, a GPIO output register, and a one-shot down-count timer with a sticky expiry flag.
- Read data is combinational, because the core completes each load in one cycle. All writes and register updates happen on the clock edge.

Parameters:
- MEM_WORDS, 64, number of 32-bit RAM words; must be a power of two and at least 4.
- MMIO_BASE, 32'hFFFF_FF00, base of the 256-byte I/O window; bits [7:0] must be zero.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- memwrite  input  1  write strobe from the core, sampled on rising clk.
- addr  input  32  byte address (core aluout); bits [1:0] are ignored.
- writedata  input  32  store data.
- readdata  output  32  load data, combinational from addr and current state.
- gpio_out  output  32  GPIO register contents.
- timer_irq  output  1  equal to the sticky EXPIRED flag.

Behaviour:
- Address decode:
  - MMIO hit when addr[31:8] == MMIO_BASE[31:8]; the register offset is addr[7:0].
  - Otherwise RAM, word index addr[$clog2(MEM_WORDS)+1:2]. Upper bits are ignored, so RAM aliases.
- Reads are zero-latency: readdata reflects the value before any write in the same cycle. A write is visible on readdata the cycle after the edge.
- RAM:
  - Written on the rising clk edge when memwrite=1 and decode is RAM.
  - Not reset; contents are undefined until written.
- MMIO registers, by offset:
  - 0x00 CYCLE (R/W):
    - Increments by 1 every cycle and wraps 32'hFFFF_FFFF -> 0.
    - A write loads writedata and takes precedence over the increment; the next read returns exactly writedata.
  - 0x04 GPIO (R/W): holds the written value; drives gpio_out.
  - 0x08 TIMER (R/W):
    - A write loads writedata as the count.
    - Each cycle with count != 0 and no write, count decrements.
    - On the edge where count goes 1 -> 0, EXPIRED sets.
    - Writing 0 stops the timer without setting EXPIRED.
    - Writing during a countdown reloads it; that cycle does not decrement.
  - 0x0C STATUS:
    - Reads {31'b0, EXPIRED}.
    - A write with writedata[0]=1 clears EXPIRED; writes with bit0=0 do nothing.
    - If a clear and a 1 -> 0 expiry occur on the same edge, set wins.
  - Any other offset reads 0; writes to it are ignored.
- Reset (reset=0, asynchronous):
  - CYCLE, GPIO, TIMER and EXPIRED all go to 0, so gpio_out=0 and timer_irq=0.
  - readdata for an MMIO address reflects these zeros immediately.
  - Reset during a countdown cancels it and does not set the flag.
  - A memwrite coinciding with reset is discarded.
- CYCLE first reads 0 in the cycle after reset deasserts, then 1, 2, ...

Decomposition:
- Shared package dmem_pkg:
  - Offset constants OFF_CYCLE=8'h00, OFF_GPIO=8'h04, OFF_TIMER=8'h08, OFF_STATUS=8'h0C.
  - Default MMIO_BASE.
- One sub-module, mmio_timer: TIMER count, EXPIRED flag and the set/clear priority. Its inputs are load, load_value and clr; its outputs are count and expired.
- RAM, CYCLE, GPIO and the read mux stay in dmem_responder.

Test Plan:
- RAM write then read: write 32'hDEAD_BEEF to 0x0000_0010, then read 0x10 -> DEAD_BEEF. Read 0x0000_0110 with MEM_WORDS=64 (alias) -> DEAD_BEEF.
- Combinational read: in the same cycle as a write of 32'h1234 to 0x14 (prior content 0x5), readdata=0x5; the next cycle reads 0x1234.
- CYCLE:
  - Release reset, read 0xFFFF_FF00 over 3 cycles -> 0, 1, 2.
  - Write 32'hFFFF_FFFE, then read over 3 cycles -> FFFF_FFFE, FFFF_FFFF, 0.
- TIMER:
  - Write 3 to 0xFFFF_FF08 -> the following reads are 3, 2, 1, 0, and timer_irq rises on the edge to 0.
  - STATUS reads 1; write 1 to 0xFFFF_FF0C -> timer_irq=0.
  - Set/clear race: write 1 to TIMER, and on the next edge write 1 to STATUS -> timer_irq=1 afterwards.
- GPIO and unmapped:
  - Write 32'hA5A5_0F0F to 0xFFFF_FF04 -> gpio_out=A5A5_0F0F.
  - Write to 0xFFFF_FF20 -> no effect, and reading it returns 0.
- Mid-operation reset: load TIMER=100 and GPIO=7, assert reset asynchronously mid-cycle -> gpio_out=0 and TIMER=0 immediately. No irq after release.
